// File: rtl/dat_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dat_mem_arbiter
//
// Shares the single-port data memory between two requesters: port 0 is the
// core load/store unit and port 1 is the init/DMA loader. One access is
// granted per cycle. Unlocked traffic is shared round-robin. A locked burst
// keeps its grant until it has used MAX_LOCK beats while the other port waits.
//
// Ports
//   clk, reset           clock and synchronous active-high reset
//   reqN                 port N request, held until ackN
//   weN                  port N write (1) / read (0)
//   lockN                port N burst lock, asks to keep the grant across beats
//   addrN, wdataN        port N address and write data
//   ackN                 port N access performed this cycle
//   rdataN               port N read data, valid when ackN & !weN
//   mem_addr             address to the memory
//   mem_data_in          write data to the memory
//   mem_wr_en            write enable to the memory
//   mem_data_out         combinational read data from the memory
// -----------------------------------------------------------------------------
module dat_mem_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_LOCK = 4
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          req0,
   input  logic          we0,
   input  logic          lock0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,

   input  logic          req1,
   input  logic          we1,
   input  logic          lock1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,

   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data_in,
   output logic          mem_wr_en,
   input  logic [DW-1:0] mem_data_out
);

   // The lock counter only has to reach MAX_LOCK-1; beyond that it saturates.
   localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(MAX_LOCK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic           rrPtr_q, rrPtr_d;
   logic [LCW-1:0] lockCnt_q, lockCnt_d;

   logic   beat0, beat1;
   logic   selfReq, selfLock, otherReq, keepGrant;
   state_e selfState, otherState;

   // A beat happens only while the granted port still requests. Reset kills
   // the beat outright so an in-flight write never reaches the memory.
   assign beat0 = !reset && (state_q == GNT0) && req0;
   assign beat1 = !reset && (state_q == GNT1) && req1;

   assign ack0 = beat0;
   assign ack1 = beat1;

   // Memory side is steered from the granted port only during a real beat;
   // otherwise everything is parked at zero.
   always_comb begin
      mem_addr    = '0;
      mem_data_in = '0;
      mem_wr_en   = 1'b0;
      rdata0      = '0;
      rdata1      = '0;
      if (beat0) begin
         mem_addr    = addr0;
         mem_data_in = wdata0;
         mem_wr_en   = we0;
         rdata0      = mem_data_out;
      end else if (beat1) begin
         mem_addr    = addr1;
         mem_data_in = wdata1;
         mem_wr_en   = we1;
         rdata1      = mem_data_out;
      end
   end

   // View the current grant from the owner's side so the end-of-beat rule is
   // written once for both ports.
   always_comb begin
      selfReq    = 1'b0;
      selfLock   = 1'b0;
      otherReq   = 1'b0;
      selfState  = IDLE;
      otherState = IDLE;
      case (state_q)
         GNT0: begin
            selfReq    = req0;
            selfLock   = lock0;
            otherReq   = req1;
            selfState  = GNT0;
            otherState = GNT1;
         end
         GNT1: begin
            selfReq    = req1;
            selfLock   = lock1;
            otherReq   = req0;
            selfState  = GNT1;
            otherState = GNT0;
         end
         default: begin
         end
      endcase
      keepGrant = selfLock && selfReq && (!otherReq || (lockCnt_q < LOCK_LIMIT));
   end

   // Next-state decision. A locked burst continues while the cap allows it;
   // when a grant ends the pointer moves to the other port, which is served
   // next without a bubble if it is waiting. A sole requester keeps going.
   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      lockCnt_d = lockCnt_q;
      if (state_q == IDLE) begin
         if (req0 && req1) begin
            state_d = rrPtr_q ? GNT1 : GNT0;
         end else if (req0) begin
            state_d = GNT0;
         end else if (req1) begin
            state_d = GNT1;
         end
      end else if (keepGrant) begin
         lockCnt_d = (&lockCnt_q) ? lockCnt_q : lockCnt_q + 1'b1;
      end else begin
         rrPtr_d   = (state_q == GNT0);
         lockCnt_d = '0;
         if (otherReq) begin
            state_d = otherState;
         end else if (selfReq) begin
            state_d = selfState;
         end else begin
            state_d = IDLE;
         end
      end
   end

   // All registered arbiter state: grant owner, fairness pointer, burst count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         rrPtr_q   <= 1'b0;
         lockCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         lockCnt_q <= lockCnt_d;
      end
   end

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dat_mem_arbiter
//
// Drives dat_mem_arbiter against a simple 256x8 memory with combinational
// read. A cycle-by-cycle vector table covers reset, single accesses and
// unlocked contention; queued traffic with a scoreboard covers locked bursts;
// a hand-written sequence covers reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_dat_mem_arbiter;

   localparam int AW       = 8;
   localparam int DW       = 8;
   localparam int MAX_LOCK = 4;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
   logic [AW-1:0] addr0 = '0;
   logic [DW-1:0] wdata0 = '0;
   logic          req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
   logic [AW-1:0] addr1 = '0;
   logic [DW-1:0] wdata1 = '0;
   logic          ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic          mem_wr_en;
   logic [DW-1:0] mem_data_out;

   int checks = 0;
   int fails  = 0;
   bit sbOn   = 1'b0;

   // Backdoor loading of the memory goes through the same write process.
   logic          pokeEn   = 1'b0;
   logic [AW-1:0] pokeAddr = '0;
   logic [DW-1:0] pokeData = '0;
   logic [DW-1:0] tbMem [0:255] = '{default: 8'h00};

   dat_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0         (req0),
      .we0          (we0),
      .lock0        (lock0),
      .addr0        (addr0),
      .wdata0       (wdata0),
      .ack0         (ack0),
      .rdata0       (rdata0),
      .req1         (req1),
      .we1          (we1),
      .lock1        (lock1),
      .addr1        (addr1),
      .wdata1       (wdata1),
      .ack1         (ack1),
      .rdata1       (rdata1),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_wr_en    (mem_wr_en),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on the rising edge.
   assign mem_data_out = tbMem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         tbMem[mem_addr] <= mem_data_in;
      end else if (pokeEn) begin
         tbMem[pokeAddr] <= pokeData;
      end
   end

   typedef struct packed {
      logic       rst;
      logic       r0, w0, l0;
      logic [7:0] a0, d0;
      logic       r1, w1, l1;
      logic [7:0] a1, d1;
      logic       eAck0, eAck1, eWe;
      logic [7:0] eAddr, eData, eRd0, eRd1;
   } vec_t;

   typedef struct packed {
      logic       we, lock;
      logic [7:0] addr, wdata;
   } tx_t;

   typedef struct packed {
      logic       port, we;
      logic [7:0] addr, data;
   } exp_t;

   vec_t vecs [18];
   tx_t  txQ0 [$];
   tx_t  txQ1 [$];
   exp_t expQ [$];

   function automatic tx_t mkTx(input logic we, input logic lock, input logic [7:0] addr, input logic [7:0] wdata);
      tx_t t;
      t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   function automatic exp_t mkExp(input logic port, input logic we, input logic [7:0] addr, input logic [7:0] data);
      exp_t e;
      e.port = port; e.we = we; e.addr = addr; e.data = data;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset  = v.rst;
      req0   = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
      req1   = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req0 = 1'b0; lock0 = 1'b0;
         req1 = 1'b0; lock1 = 1'b0;
      end
   endtask

   // Each port presents the head of its transaction queue until acked.
   task automatic runTraffic(input string name, input int maxCycles, output int cycles);
      cycles = 0;
      while ((txQ0.size() > 0 || txQ1.size() > 0) && cycles < maxCycles) begin
         @(posedge clk); #1;
         req0 = (txQ0.size() > 0);
         if (req0) begin
            we0 = txQ0[0].we; lock0 = txQ0[0].lock; addr0 = txQ0[0].addr; wdata0 = txQ0[0].wdata;
         end
         req1 = (txQ1.size() > 0);
         if (req1) begin
            we1 = txQ1[0].we; lock1 = txQ1[0].lock; addr1 = txQ1[0].addr; wdata1 = txQ1[0].wdata;
         end
         #3;
         cycles++;
         if (ack0 && txQ0.size() > 0) void'(txQ0.pop_front());
         if (ack1 && txQ1.size() > 0) void'(txQ1.pop_front());
      end
      if (txQ0.size() > 0 || txQ1.size() > 0) begin
         checks++;
         fails++;
         $display("[TB] FAIL %s timeout: %0d beats left after %0d cycles, expected 0", name, txQ0.size() + txQ1.size(), cycles);
         txQ0.delete();
         txQ1.delete();
      end
      idleCycles(2);
   endtask

   // Scoreboard: every ack is matched against the next expected access, and
   // the grant invariants are checked each cycle.
   always @(negedge clk) begin
      if (sbOn) begin
         checks++;
         if ((ack0 && ack1) || (mem_wr_en && !((ack0 && we0) || (ack1 && we1)))) begin
            fails++;
            $display("[TB] FAIL invariant: ack0=%0b ack1=%0b mem_wr_en=%0b, required single ack owning the write", ack0, ack1, mem_wr_en);
         end
         if (ack0 || ack1) begin
            exp_t act;
            exp_t e;
            act.port = ack1;
            act.we   = mem_wr_en;
            act.addr = mem_addr;
            act.data = mem_wr_en ? mem_data_in : (ack1 ? rdata1 : rdata0);
            checks++;
            if (expQ.size() == 0) begin
               fails++;
               $display("[TB] FAIL unexpected ack: got port=%0d addr=%0h data=%0h, expected none", act.port, act.addr, act.data);
            end else begin
               e = expQ.pop_front();
               if (act !== e) begin
                  fails++;
                  $display("[TB] FAIL beat: got port=%0d we=%0b addr=%0h data=%0h, expected port=%0d we=%0b addr=%0h data=%0h",
                           act.port, act.we, act.addr, act.data, e.port, e.we, e.addr, e.data);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;

      //          rst r0 w0 l0 a0     d0     r1 w1 l1 a1     d1     eA0 eA1 eWe eAddr eData  eRd0   eRd1
      vecs[0]  = '{1'b1, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[1]  = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[2]  = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b1,1'b0,1'b0, 8'h10,8'h00,8'hA5,8'h00};
      vecs[3]  = '{1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[4]  = '{1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b1,1'b1,1'b0, 8'h20,8'h3C, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[5]  = '{1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b1,1'b1,1'b0, 8'h20,8'h3C, 1'b0,1'b1,1'b1, 8'h20,8'h3C,8'h00,8'h00};
      vecs[6]  = '{1'b0, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[7]  = '{1'b0, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00,8'h3C,8'h00};
      vecs[8]  = '{1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[9]  = '{1'b1, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[10] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};
      vecs[11] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b1,1'b0,1'b0, 8'h10,8'h00,8'hA5,8'h00};
      vecs[12] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b0,1'b1,1'b0, 8'h20,8'h00,8'h00,8'h3C};
      vecs[13] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b1,1'b0,1'b0, 8'h10,8'h00,8'hA5,8'h00};
      vecs[14] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b0,1'b1,1'b0, 8'h20,8'h00,8'h00,8'h3C};
      vecs[15] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b1,1'b0,1'b0, 8'h10,8'h00,8'hA5,8'h00};
      vecs[16] = '{1'b0, 1'b1,1'b0,1'b0, 8'h10,8'h00, 1'b1,1'b0,1'b0, 8'h20,8'h00, 1'b0,1'b1,1'b0, 8'h20,8'h00,8'h00,8'h3C};
      vecs[17] = '{1'b0, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00};

      // Preload mem[0x10] while reset holds the arbiter quiet.
      pokeEn = 1'b1; pokeAddr = 8'h10; pokeData = 8'hA5;
      repeat (2) @(posedge clk);
      #1 pokeEn = 1'b0;

      // Cycle-accurate vectors: reset, single read, write/readback, contention.
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         applyStimulus(vecs[i]);
         #3;
         checkOutput($sformatf("vector %0d", i),
                     {29'd0, ack0, ack1, mem_wr_en, mem_addr, mem_data_in, rdata0, rdata1},
                     {29'd0, vecs[i].eAck0, vecs[i].eAck1, vecs[i].eWe, vecs[i].eAddr, vecs[i].eData, vecs[i].eRd0, vecs[i].eRd1});
      end

      // Locked burst cap: port 1 locked writes against a waiting port 0.
      sbOn = 1'b1;
      for (int i = 0; i < 8; i++) txQ1.push_back(mkTx(1'b1, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i)));
      txQ0.push_back(mkTx(1'b0, 1'b0, 8'h40, 8'h00));
      txQ0.push_back(mkTx(1'b0, 1'b0, 8'h44, 8'h00));
      for (int i = 0; i < 4; i++) expQ.push_back(mkExp(1'b1, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i)));
      expQ.push_back(mkExp(1'b0, 1'b0, 8'h40, 8'h80));
      for (int i = 4; i < 8; i++) expQ.push_back(mkExp(1'b1, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i)));
      expQ.push_back(mkExp(1'b0, 1'b0, 8'h44, 8'h84));
      runTraffic("lock cap", 40, cyc);
      checkOutput("lock cap cycles", 64'(cyc), 64'd11);
      checkOutput("lock cap leftovers", 64'(expQ.size()), 64'd0);
      expQ.delete();

      // Unopposed locked burst: eight back-to-back beats for port 0.
      for (int i = 0; i < 8; i++) begin
         txQ0.push_back(mkTx(1'b1, 1'b1, 8'(8'h60 + i), 8'(8'hC0 + i)));
         expQ.push_back(mkExp(1'b0, 1'b1, 8'(8'h60 + i), 8'(8'hC0 + i)));
      end
      runTraffic("lock unopposed", 40, cyc);
      checkOutput("lock unopposed cycles", 64'(cyc), 64'd9);
      checkOutput("lock unopposed leftovers", 64'(expQ.size()), 64'd0);
      expQ.delete();
      sbOn = 1'b0;

      // Reset in the middle of a port 0 write burst; pointer currently favours port 1.
      @(posedge clk); #1;
      pokeEn = 1'b1; pokeAddr = 8'h55; pokeData = 8'h11;
      @(posedge clk); #1;
      pokeEn = 1'b0;
      req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 8'h54; wdata0 = 8'hEE;
      #3 checkOutput("burst arbitration cycle", {62'd0, ack0, ack1}, 64'd0);
      @(posedge clk); #1;
      #3 checkOutput("burst first beat", {46'd0, ack0, mem_wr_en, mem_addr, mem_data_in}, {46'd0, 1'b1, 1'b1, 8'h54, 8'hEE});
      @(posedge clk); #1;
      addr0 = 8'h55; wdata0 = 8'hFF; reset = 1'b1;
      #3 checkOutput("reset beat dropped", {61'd0, ack0, ack1, mem_wr_en}, 64'd0);
      checkOutput("first beat stored", 64'(tbMem[8'h54]), 64'hEE);
      @(posedge clk); #1;
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h55;
      req1 = 1'b1; we1 = 1'b0; lock1 = 1'b0; addr1 = 8'h63;
      #3 checkOutput("reset kept mem 0x55", 64'(tbMem[8'h55]), 64'h11);
      checkOutput("idle after reset", {62'd0, ack0, ack1}, 64'd0);
      @(posedge clk); #1;
      #3 checkOutput("port 0 first after reset", {54'd0, ack0, ack1, rdata0}, {54'd0, 1'b1, 1'b0, 8'h11});
      @(posedge clk); #1;
      req0 = 1'b0;
      #3 checkOutput("port 1 read after switch", {55'd0, ack1, rdata1}, {55'd0, 1'b1, 8'hC3});
      idleCycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
